// File: rtl/sha1_arbiter_if.sv
// sha1_arbiter_if: requester streams, core input, core result and tagged output ports of sha1_arbiter
interface sha1_arbiter_if #(parameter int N = 4);
  localparam int SW = ($clog2(N) < 1) ? 1 : $clog2(N);
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tready;
  logic [N-1:0]    s_tlast;
  logic [N*32-1:0] s_tid;
  logic [N*8-1:0]  s_tdata;
  logic            m_tready;
  logic            m_tvalid;
  logic            m_tlast;
  logic [31:0]     m_tid;
  logic [7:0]      m_tdata;
  logic            r_ovalid;
  logic [31:0]     r_oid;
  logic [60:0]     r_olen;
  logic [159:0]    r_osha;
  logic            ovalid;
  logic [SW-1:0]   osrc;
  logic [31:0]     oid;
  logic [60:0]     olen;
  logic [159:0]    osha;
  logic            err;
  logic            busy;
  modport slave (
    input  s_tvalid, s_tlast, s_tid, s_tdata, m_tready, r_ovalid, r_oid, r_olen, r_osha,
    output s_tready, m_tvalid, m_tlast, m_tid, m_tdata, ovalid, osrc, oid, olen, osha, err, busy
  );
  modport master (
    output s_tvalid, s_tlast, s_tid, s_tdata, m_tready, r_ovalid, r_oid, r_olen, r_osha,
    input  s_tready, m_tvalid, m_tlast, m_tid, m_tdata, ovalid, osrc, oid, olen, osha, err, busy
  );
endinterface

// File: rtl/sha1_arbiter.sv
// sha1_arbiter: round-robin whole-message sharing of one sha1 core, results tagged with their requester
module sha1_arbiter #(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             rstn,
  sha1_arbiter_if.slave   bus
);
  localparam int SW = ($clog2(N) < 1) ? 1 : $clog2(N);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {ARB, XFER} state_t;
  state_t        state, state_nx;
  logic [SW-1:0] grant, last, pick, hi_pick, lo_pick;
  logic          hi_found, found, push, pop, full, empty;
  logic [SW-1:0] fifo [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  assign full  = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign pop   = bus.r_ovalid && !empty;
  assign found = |bus.s_tvalid;
  assign pick  = hi_found ? hi_pick : lo_pick;
  assign bus.busy = (state == XFER) || !empty;
  // lowest valid index above last wins, otherwise wrap to the lowest valid index
  always_comb begin
    hi_found = 1'b0;
    hi_pick  = '0;
    lo_pick  = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (bus.s_tvalid[j] && SW'(j) > last) begin
        hi_found = 1'b1;
        hi_pick  = SW'(j);
      end
      if (bus.s_tvalid[j]) lo_pick = SW'(j);
    end
  end
  always_comb begin
    state_nx     = state;
    push         = 1'b0;
    bus.m_tvalid = 1'b0;
    bus.m_tlast  = 1'b0;
    bus.m_tid    = '0;
    bus.m_tdata  = '0;
    bus.s_tready = '0;
    for (int i = 0; i < N; i++) begin
      if (state == XFER && grant == SW'(i)) begin
        bus.m_tvalid    = bus.s_tvalid[i];
        bus.m_tlast     = bus.s_tlast[i];
        bus.m_tid       = bus.s_tid[32*i +: 32];
        bus.m_tdata     = bus.s_tdata[8*i +: 8];
        bus.s_tready[i] = bus.m_tready;
      end
    end
    if (state == ARB) begin
      push     = found && !full;
      state_nx = push ? XFER : ARB;
    end else if (bus.m_tvalid && bus.m_tready && bus.m_tlast) begin
      state_nx = ARB;
    end
  end
  always_ff @(posedge clk) if (push) fifo[wp] <= pick;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ARB;
      grant      <= '0;
      last       <= SW'(N - 1);
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
      bus.ovalid <= 1'b0;
      bus.osrc   <= '0;
      bus.oid    <= '0;
      bus.olen   <= '0;
      bus.osha   <= '0;
      bus.err    <= 1'b0;
    end else begin
      state      <= state_nx;
      grant      <= push ? pick : grant;
      last       <= push ? pick : last;
      wp         <= push ? wp + 1'b1 : wp;
      rp         <= pop ? rp + 1'b1 : rp;
      cnt        <= (push && !pop) ? cnt + 1'b1 : (!push && pop) ? cnt - 1'b1 : cnt;
      bus.ovalid <= bus.r_ovalid;
      bus.err    <= bus.err || (bus.r_ovalid && empty);
      if (bus.r_ovalid) begin
        bus.osrc <= empty ? '0 : fifo[rp];
        bus.oid  <= bus.r_oid;
        bus.olen <= bus.r_olen;
        bus.osha <= bus.r_osha;
      end
    end
  end
endmodule

// File: tb/tb_sha1_arbiter.sv
// tb_sha1_arbiter: directed scoreboard bench; the bench plays the sha1 core behind the arbiter
module tb_sha1_arbiter;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;
  sha1_arbiter_if #(.N(4)) b4 ();
  sha1_arbiter_if #(.N(4)) b2 ();
  sha1_arbiter #(.N(4), .DEPTH(4)) u4 (.clk(clk), .rstn(rstn), .bus(b4));
  sha1_arbiter #(.N(4), .DEPTH(2)) u2 (.clk(clk), .rstn(rstn), .bus(b2));
  typedef struct {
    logic [1:0]   src;
    logic [31:0]  id;
    logic [60:0]  len;
    logic [159:0] sha;
  } exp_t;
  localparam logic [159:0] ABC = 160'hA9993E364706816ABA3E25717850C26C9CD0D89D;
  exp_t        sb_q[$];
  logic [92:0] core_q[$];
  int          checks = 0;
  int          errors = 0;
  int          nbytes = 0;
  int          viol;
  bit          done2;
  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [159:0] sha_of(input logic [31:0] id);
    return (id == 32'h11) ? ABC : {128'h0, id};
  endfunction
  task automatic expect_res(input logic [1:0] src, input logic [31:0] id, input logic [60:0] len,
                            input logic [159:0] sha);
    exp_t e;
    e.src = src; e.id = id; e.len = len; e.sha = sha;
    sb_q.push_back(e);
  endtask
  // one requester sends an n-byte message d0, d0+1, ...
  task automatic stream(input int i, input logic [31:0] id, input int n, input logic [7:0] d0);
    int t;
    for (int k = 0; k < n; k++) begin
      b4.s_tvalid[i]         = 1'b1;
      b4.s_tlast[i]          = (k == n - 1);
      b4.s_tid[32*i +: 32]   = id;
      b4.s_tdata[8*i +: 8]   = d0 + 8'(k);
      t = 0;
      @(negedge clk);
      while (!b4.s_tready[i] && t < 500) begin
        @(negedge clk);
        t++;
      end
      if (!b4.s_tready[i]) begin
        checks++;
        errors++;
        $display("FAIL stream_timeout: requester %0d byte %0d never accepted", i, k);
        b4.s_tvalid[i] = 1'b0;
        b4.s_tlast[i]  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    b4.s_tvalid[i] = 1'b0;
    b4.s_tlast[i]  = 1'b0;
  endtask
  task automatic core_return();
    logic [92:0] e;
    int t = 0;
    while (core_q.size() == 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (core_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL core_timeout: no message reached the core input, got 0 expected 1");
      return;
    end
    e = core_q.pop_front();
    @(posedge clk); #1;
    b4.r_ovalid = 1'b1;
    b4.r_oid    = e[92:61];
    b4.r_olen   = e[60:0];
    b4.r_osha   = sha_of(e[92:61]);
    @(posedge clk); #1;
    b4.r_ovalid = 1'b0;
  endtask
  task automatic pulse2();
    @(posedge clk); #1; b2.r_ovalid = 1'b1;
    @(posedge clk); #1; b2.r_ovalid = 1'b0;
  endtask
  // core model: collects accepted messages in order
  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      nbytes = 0;
      core_q.delete();
    end else if (b4.m_tvalid && b4.m_tready) begin
      nbytes++;
      if (b4.m_tlast) begin
        core_q.push_back({b4.m_tid, 61'(nbytes)});
        nbytes = 0;
      end
    end
  end
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (b4.ovalid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got osrc=%0d oid=%0h, expected no result", b4.osrc, b4.oid);
      end else begin
        e = sb_q.pop_front();
        check("osrc", 192'(b4.osrc), 192'(e.src));
        check("oid", 192'(b4.oid), 192'(e.id));
        check("olen", 192'(b4.olen), 192'(e.len));
        check("osha", 192'(b4.osha), 192'(e.sha));
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rstn = 1'b0;
    b4.s_tvalid = '0; b4.s_tlast = '0; b4.s_tid = '0; b4.s_tdata = '0; b4.m_tready = 1'b1;
    b4.r_ovalid = 1'b0; b4.r_oid = '0; b4.r_olen = '0; b4.r_osha = '0;
    b2.s_tvalid = '0; b2.s_tlast = '0; b2.s_tid = '0; b2.s_tdata = '0; b2.m_tready = 1'b1;
    b2.r_ovalid = 1'b0; b2.r_oid = '0; b2.r_olen = '0; b2.r_osha = '0;
    repeat (3) @(negedge clk);
    check("rst_ovalid", 192'(b4.ovalid), 192'(0));
    check("rst_err", 192'(b4.err), 192'(0));
    check("rst_busy", 192'(b4.busy), 192'(0));
    check("rst_s_tready", 192'(b4.s_tready), 192'(0));
    check("rst_m_tvalid", 192'(b4.m_tvalid), 192'(0));
    check("rst_osrc", 192'(b4.osrc), 192'(0));
    rstn = 1'b1;
    // "abc" from requester 0
    @(posedge clk); #1;
    expect_res(2'd0, 32'h11, 61'd3, ABC);
    stream(0, 32'h11, 3, 8'h61);
    core_return();
    repeat (3) @(negedge clk);
    check("abc_idle_busy", 192'(b4.busy), 192'(0));
    // four simultaneous single-byte messages after reset
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) expect_res(2'(i), 32'h20 + 32'(i), 61'd1, {128'h0, 32'h20 + 32'(i)});
    fork
      stream(0, 32'h20, 1, 8'hA0);
      stream(1, 32'h21, 1, 8'hA1);
      stream(2, 32'h22, 1, 8'hA2);
      stream(3, 32'h23, 1, 8'hA3);
    join
    @(negedge clk);
    check("full_busy", 192'(b4.busy), 192'(1));
    repeat (4) core_return();
    // long message on 2 is not preempted; then 3, then 0
    expect_res(2'd2, 32'h32, 61'd64, {128'h0, 32'h32});
    expect_res(2'd3, 32'h33, 61'd1, {128'h0, 32'h33});
    expect_res(2'd0, 32'h30, 61'd1, {128'h0, 32'h30});
    done2 = 1'b0;
    viol  = 0;
    fork
      begin stream(2, 32'h32, 64, 8'h00); done2 = 1'b1; end
      begin
        repeat (3) @(posedge clk);
        #1;
        fork
          stream(3, 32'h33, 1, 8'h33);
          stream(0, 32'h30, 1, 8'h30);
        join
      end
      while (!done2) begin
        @(negedge clk);
        if (b4.s_tready[0] || b4.s_tready[3]) viol++;
      end
    join
    check("no_preempt", 192'(viol), 192'(0));
    repeat (3) core_return();
    // DEPTH=2 instance: full blocks grants, including the cycle of the pop
    @(posedge clk); #1;
    b2.s_tvalid[0] = 1'b1; b2.s_tlast[0] = 1'b1; b2.s_tid[31:0] = 32'h80;
    @(negedge clk); @(negedge clk);
    check("d2_grant0", 192'(b2.s_tready[0]), 192'(1));
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    b2.s_tvalid[0] = 1'b0; b2.s_tlast[0] = 1'b0;
    b2.s_tvalid[1] = 1'b1; b2.s_tlast[1] = 1'b1; b2.s_tid[63:32] = 32'h81;
    @(negedge clk);
    check("d2_full_a", 192'(b2.s_tready[1]), 192'(0));
    @(negedge clk);
    check("d2_full_b", 192'(b2.s_tready[1]), 192'(0));
    check("d2_busy", 192'(b2.busy), 192'(1));
    pulse2();
    @(negedge clk);
    check("d2_no_grant_on_pop", 192'(b2.s_tready[1]), 192'(0));
    check("d2_ovalid", 192'(b2.ovalid), 192'(1));
    check("d2_osrc_a", 192'(b2.osrc), 192'(0));
    @(negedge clk);
    check("d2_grant_after_pop", 192'(b2.s_tready[1]), 192'(1));
    @(posedge clk); #1;
    b2.s_tvalid[1] = 1'b0; b2.s_tlast[1] = 1'b0;
    pulse2();
    @(negedge clk);
    check("d2_osrc_b", 192'(b2.osrc), 192'(0));
    pulse2();
    @(negedge clk);
    check("d2_osrc_c", 192'(b2.osrc), 192'(1));
    @(negedge clk);
    check("d2_idle", 192'(b2.busy), 192'(0));
    // result with nothing outstanding
    expect_res(2'd0, 32'hEE, 61'd5, {128'h0, 32'hEE});
    @(posedge clk); #1;
    b4.r_ovalid = 1'b1; b4.r_oid = 32'hEE; b4.r_olen = 61'd5; b4.r_osha = {128'h0, 32'hEE};
    @(posedge clk); #1;
    b4.r_ovalid = 1'b0;
    @(negedge clk);
    check("err_set", 192'(b4.err), 192'(1));
    repeat (3) @(negedge clk);
    check("err_busy", 192'(b4.busy), 192'(0));
    @(posedge clk); #1;
    expect_res(2'd2, 32'h70, 61'd2, {128'h0, 32'h70});
    stream(2, 32'h70, 2, 8'h70);
    core_return();
    repeat (2) @(negedge clk);
    check("err_sticky", 192'(b4.err), 192'(1));
    // reset in the middle of requester 1's message
    @(posedge clk); #1;
    b4.s_tvalid[1] = 1'b1; b4.s_tlast[1] = 1'b0; b4.s_tid[63:32] = 32'h61; b4.s_tdata[15:8] = 8'hAA;
    @(negedge clk); @(negedge clk);
    check("mid_tready", 192'(b4.s_tready[1]), 192'(1));
    #2;
    rstn = 1'b0;
    #1;
    check("mrst_s_tready", 192'(b4.s_tready), 192'(0));
    check("mrst_m_tvalid", 192'(b4.m_tvalid), 192'(0));
    check("mrst_ovalid", 192'(b4.ovalid), 192'(0));
    check("mrst_busy", 192'(b4.busy), 192'(0));
    check("mrst_err", 192'(b4.err), 192'(0));
    b4.s_tvalid[1] = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    expect_res(2'd0, 32'h60, 61'd1, {128'h0, 32'h60});
    expect_res(2'd2, 32'h62, 61'd1, {128'h0, 32'h62});
    @(posedge clk); #1;
    fork
      stream(0, 32'h60, 1, 8'h60);
      stream(2, 32'h62, 1, 8'h62);
      begin
        @(negedge clk); @(negedge clk);
        check("tie_tready0", 192'(b4.s_tready[0]), 192'(1));
        check("tie_tready2", 192'(b4.s_tready[2]), 192'(0));
      end
    join
    repeat (2) core_return();
    repeat (4) @(negedge clk);
    check("sb_drained", 192'(sb_q.size()), 192'(0));
    check("end_busy", 192'(b4.busy), 192'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
